// File: rtl/trig_record_fifo.sv
// trig_record_fifo: FWFT capture queue for trigger records {mask, timestamp} with saturating overflow count.
// Optional merge stage in front of the queue when TRIG_RECORD_MERGE_EN is defined.
module trig_record_fifo #(
    parameter int DEPTH  = 16,
    parameter int MASK_W = 8,
    parameter int TS_W   = 56
) (
    input  logic                       clk_adc,
    input  logic                       reset,
    input  logic                       trig_valid,
    input  logic [MASK_W-1:0]          trig_mask,
    input  logic [TS_W-1:0]            trig_time,
    input  logic [7:0]                 merge_window,
    input  logic                       flush,
    input  logic                       rd_en,
    output logic                       rd_valid,
    output logic [MASK_W-1:0]          rd_mask,
    output logic [TS_W-1:0]            rd_time,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                overflow_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic              w_wr_req;
    logic [MASK_W-1:0] w_wr_mask;
    logic [TS_W-1:0]   w_wr_time;
    logic              w_cand;

    assign w_cand = trig_valid && (|trig_mask);

`ifdef TRIG_RECORD_MERGE_EN
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t            r_state, w_state_nx;
    logic [7:0]        r_timer, w_timer_nx;
    logic [MASK_W-1:0] r_mask, w_mask_nx, w_or;
    logic [TS_W-1:0]   r_time, w_time_nx;

    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset || flush) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_mask  <= '0;
            r_time  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_timer <= w_timer_nx;
            r_mask  <= w_mask_nx;
            r_time  <= w_time_nx;
        end
    end

    assign w_or = r_mask | (trig_valid ? trig_mask : '0);

    always_comb begin
        w_state_nx = r_state;
        w_timer_nx = r_timer;
        w_mask_nx  = r_mask;
        w_time_nx  = r_time;
        w_wr_req   = 1'b0;
        w_wr_mask  = trig_mask;
        w_wr_time  = trig_time;
        if (r_state == IDLE) begin
            if (w_cand && merge_window == 8'd0) begin
                w_wr_req = 1'b1;
            end else if (w_cand) begin
                w_state_nx = COLLECT;
                w_timer_nx = merge_window;
                w_mask_nx  = trig_mask;
                w_time_nx  = trig_time;
            end
        end else begin
            w_mask_nx = w_or;
            // The closing cycle still absorbs a mask arriving with it.
            if (r_timer == 8'd1) begin
                w_wr_req   = 1'b1;
                w_wr_mask  = w_or;
                w_wr_time  = r_time;
                w_state_nx = IDLE;
            end else begin
                w_timer_nx = r_timer - 8'd1;
            end
        end
    end
`else
    logic w_unused_mw;
    assign w_unused_mw = ^merge_window;
    assign w_wr_req    = w_cand;
    assign w_wr_mask   = trig_mask;
    assign w_wr_time   = trig_time;
`endif

    logic [MASK_W-1:0] r_mem_mask [DEPTH];
    logic [TS_W-1:0]   r_mem_time [DEPTH];
    logic [AW-1:0]     r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic [15:0]       r_ovf;
    logic              w_pop, w_push, w_drop;

    assign full           = (r_count == FULL_CNT);
    assign rd_valid       = (r_count != '0);
    assign count          = r_count;
    assign overflow_count = r_ovf;
    assign rd_mask        = r_mem_mask[r_rd_ptr];
    assign rd_time        = r_mem_time[r_rd_ptr];

    // Flush overrides both ends, so a flush cycle neither stores nor drops.
    assign w_pop  = rd_en && rd_valid && !flush;
    assign w_push = w_wr_req && !flush && (!full || w_pop);
    assign w_drop = w_wr_req && !flush && full && !w_pop;

    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push != w_pop)
                r_count <= w_push ? r_count + 1'b1 : r_count - 1'b1;
            if (w_drop && r_ovf != 16'hFFFF)
                r_ovf <= r_ovf + 16'd1;
        end
    end

    always_ff @(posedge clk_adc or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem_mask[i] <= '0;
                r_mem_time[i] <= '0;
            end
        end else if (w_push) begin
            r_mem_mask[r_wr_ptr] <= w_wr_mask;
            r_mem_time[r_wr_ptr] <= w_wr_time;
        end
    end
endmodule

// File: tb/tb_trig_record_fifo.sv
// tb_trig_record_fifo: table-driven and scoreboard checks of trig_record_fifo (merge tests when TRIG_RECORD_MERGE_EN is defined).
module tb_trig_record_fifo;
    logic        clk_adc = 0;
    logic        reset;
    logic        trig_valid;
    logic [7:0]  trig_mask;
    logic [55:0] trig_time;
    logic [7:0]  merge_window;
    logic        flush;
    logic        rd_en;
    logic        rd_valid;
    logic [7:0]  rd_mask;
    logic [55:0] rd_time;
    logic        full;
    logic [4:0]  count;
    logic [15:0] overflow_count;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic [7:0]  m;
        logic [55:0] t;
    } rec_t;
    rec_t sb[$];
    int   ovf_m = 0;

    typedef struct {
        logic        v;
        logic [7:0]  m;
        logic [55:0] t;
        logic        r;
        logic        f;
        int          ec;
        int          eo;
    } vec_t;
    vec_t vecs[10];

    trig_record_fifo #(.DEPTH(16), .MASK_W(8), .TS_W(56)) dut (
        .clk_adc(clk_adc), .reset(reset), .trig_valid(trig_valid), .trig_mask(trig_mask),
        .trig_time(trig_time), .merge_window(merge_window), .flush(flush), .rd_en(rd_en),
        .rd_valid(rd_valid), .rd_mask(rd_mask), .rd_time(rd_time), .full(full),
        .count(count), .overflow_count(overflow_count)
    );

    always #5 clk_adc = ~clk_adc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_state();
        check("count", 64'(count), 64'(sb.size()));
        check("rd_valid", 64'(rd_valid), 64'(sb.size() != 0));
        check("full", 64'(full), 64'(sb.size() == 16));
        check("overflow", 64'(overflow_count), 64'(ovf_m));
        if (sb.size() != 0) begin
            check("head_mask", 64'(rd_mask), 64'(sb[0].m));
            check("head_time", 64'(rd_time), 64'(sb[0].t));
        end
    endtask

    task automatic step(input logic v, input logic [7:0] m, input logic [55:0] t, input logic r, input logic f);
        bit was_full, pop;
        @(negedge clk_adc);
        trig_valid = v; trig_mask = m; trig_time = t; rd_en = r; flush = f;
        @(posedge clk_adc);
        was_full = (sb.size() == 16);
        pop = r && sb.size() != 0;
        if (f) begin
            sb.delete();
            ovf_m = 0;
        end else begin
            if (pop) void'(sb.pop_front());
            if (v && m != 0) begin
                if (!was_full || pop) sb.push_back('{m, t});
                else if (ovf_m != 16'hFFFF) ovf_m++;
            end
        end
        #1;
        trig_valid = 0; rd_en = 0; flush = 0;
        check_state();
    endtask

    task automatic do_reset();
        @(negedge clk_adc);
        reset = 1;
        #1;
        sb.delete();
        ovf_m = 0;
        check("rst_count", 64'(count), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_mask", 64'(rd_mask), 64'd0);
        check("rst_rd_time", 64'(rd_time), 64'd0);
        check("rst_ovf", 64'(overflow_count), 64'd0);
        @(negedge clk_adc);
        reset = 0;
    endtask

    initial begin
        reset = 1; trig_valid = 0; trig_mask = 0; trig_time = 0;
        merge_window = 0; flush = 0; rd_en = 0;
        vecs[0] = '{1, 8'h05, 56'h123, 0, 0, 1, 0};
        vecs[1] = '{0, 8'h00, 56'h0,   1, 0, 0, 0};
        vecs[2] = '{0, 8'h00, 56'h0,   1, 0, 0, 0};
        vecs[3] = '{1, 8'h00, 56'h5,   0, 0, 0, 0};
        vecs[4] = '{1, 8'h03, 56'h7,   0, 0, 1, 0};
        vecs[5] = '{1, 8'h09, 56'h8,   0, 0, 2, 0};
        vecs[6] = '{1, 8'hAA, 56'h9,   0, 1, 0, 0};
        vecs[7] = '{1, 8'h11, 56'h10,  1, 0, 1, 0};
        vecs[8] = '{1, 8'h22, 56'h11,  1, 0, 1, 0};
        vecs[9] = '{0, 8'h00, 56'h0,   1, 0, 0, 0};
        repeat (2) @(posedge clk_adc);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_full", 64'(full), 64'd0);
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_mask", 64'(rd_mask), 64'd0);
        check("rst_rd_time", 64'(rd_time), 64'd0);
        check("rst_ovf", 64'(overflow_count), 64'd0);
        @(negedge clk_adc);
        reset = 0;

        foreach (vecs[i]) begin
            step(vecs[i].v, vecs[i].m, vecs[i].t, vecs[i].r, vecs[i].f);
            check($sformatf("vec%0d_count", i), 64'(count), 64'(vecs[i].ec));
            check($sformatf("vec%0d_ovf", i), 64'(overflow_count), 64'(vecs[i].eo));
        end

        for (int i = 0; i < 18; i++)
            step(1, 8'(i + 1), 56'(1000 + i), 0, 0);
        check("ovf_full", 64'(full), 64'd1);
        check("ovf_count", 64'(count), 64'd16);
        check("ovf_overflow", 64'(overflow_count), 64'd2);

        step(1, 8'hF0, 56'd5000, 1, 0);
        check("pp_count", 64'(count), 64'd16);
        check("pp_overflow", 64'(overflow_count), 64'd2);
        for (int i = 0; i < 15; i++)
            step(0, 8'h00, 56'd0, 1, 0);
        check("pp_last_time", 64'(rd_time), 64'd5000);
        step(0, 8'h00, 56'd0, 1, 0);
        check("drained", 64'(rd_valid), 64'd0);

        for (int i = 0; i < 17; i++)
            step(1, 8'h40, 56'(2000 + i), 0, 0);
        step(0, 8'h00, 56'd0, 0, 1);
        check("flush_ovf", 64'(overflow_count), 64'd0);

        for (int i = 0; i < 3; i++)
            step(1, 8'h7, 56'(3000 + i), 0, 0);
        do_reset();
        step(1, 8'h02, 56'h42, 0, 0);
        step(0, 8'h00, 56'd0, 1, 0);

`ifdef TRIG_RECORD_MERGE_EN
        merge_window = 3;
        @(negedge clk_adc);
        trig_valid = 1; trig_mask = 8'h01; trig_time = 56'd100;
        @(negedge clk_adc);
        trig_mask = 8'h04; trig_time = 56'd200;
        @(negedge clk_adc);
        trig_valid = 0;
        @(negedge clk_adc);
        check("merge_early", 64'(rd_valid), 64'd0);
        trig_valid = 1; trig_mask = 8'h80; trig_time = 56'd300;
        @(posedge clk_adc);
        #1;
        trig_valid = 0;
        check("merge_valid", 64'(rd_valid), 64'd1);
        check("merge_mask", 64'(rd_mask), 64'h85);
        check("merge_time", 64'(rd_time), 64'd100);
        check("merge_count", 64'(count), 64'd1);
        do_reset();
        @(negedge clk_adc);
        trig_valid = 1; trig_mask = 8'h10; trig_time = 56'd400;
        @(negedge clk_adc);
        trig_valid = 0;
        do_reset();
        repeat (5) @(posedge clk_adc);
        #1;
        check("midmerge_count", 64'(count), 64'd0);
        merge_window = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
